pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, and synchronous flush with bubble insertion. It generalises the fixed IF/ID latch to any stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB. It is instantiated between every stage pair of the core pipeline. Stall comes from output backpressure, not from a separate enable.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_skid_entry.sv | 36 +++
 rtl/pipe_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions: payload widths, stage states and bubble payloads.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // IF/ID: instr, pc, pc+4. Later boundaries add operands/results, instr always on top.
    localparam int unsigned IFID_W  = 96;
    localparam int unsigned IDEX_W  = 192;
    localparam int unsigned EXMEM_W = 128;
    localparam int unsigned MEMWB_W = 128;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } stage_state_e;

    localparam logic [IFID_W-1:0]  IFID_BUBBLE  = {NOP_INSTR, 64'h0};
    localparam logic [IDEX_W-1:0]  IDEX_BUBBLE  = {NOP_INSTR, 160'h0};
    localparam logic [EXMEM_W-1:0] EXMEM_BUBBLE = {NOP_INSTR, 96'h0};
    localparam logic [MEMWB_W-1:0] MEMWB_BUBBLE = {NOP_INSTR, 96'h0};

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload register with a valid bit; clear wins over load and restores RST_VAL.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int unsigned        WIDTH   = IFID_W,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry and flush.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = IFID_W,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = IFID_BUBBLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt,
`endif
    input  logic             flush
);

    logic w_accept;
    logic w_consume;

    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            stage_state_e     r_state;
            stage_state_e     w_state_nxt;
            logic             r_in_ready;
            logic             w_main_load;
            logic             w_main_clear;
            logic             w_skid_load;
            logic             w_skid_clear;
            logic             w_skid_valid;
            logic [WIDTH-1:0] w_skid_dout;
            logic [WIDTH-1:0] w_main_din;

            always_comb begin
                w_state_nxt  = r_state;
                w_main_load  = 1'b0;
                w_main_clear = 1'b0;
                w_skid_load  = 1'b0;
                w_skid_clear = 1'b0;
                if (flush) begin
                    w_state_nxt  = ST_EMPTY;
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_accept) begin
                                w_main_load = 1'b1;
                                w_state_nxt = ST_FULL;
                            end
                        end
                        ST_FULL: begin
                            if (w_accept && w_consume) begin
                                w_main_load = 1'b1;
                            end else if (w_accept) begin
                                w_skid_load = 1'b1;
                                w_state_nxt = ST_SKID;
                            end else if (w_consume) begin
                                w_main_clear = 1'b1;
                                w_state_nxt  = ST_EMPTY;
                            end
                        end
                        ST_SKID: begin
                            if (w_consume) begin
                                w_main_load  = 1'b1;
                                w_skid_clear = 1'b1;
                                w_state_nxt  = ST_FULL;
                            end
                        end
                        default: w_state_nxt = ST_EMPTY;
                    endcase
                end
            end

            // The skid entry, when occupied, is always older than in_data.
            assign w_main_din = w_skid_valid ? w_skid_dout : in_data;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != ST_SKID);
                end
            end

            assign in_ready = r_in_ready;

            pipe_skid_entry #(
                .WIDTH   (WIDTH),
                .RST_VAL (BUBBLE)
            ) u_main (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_main_load),
                .i_clear (w_main_clear),
                .i_data  (w_main_din),
                .o_valid (out_valid),
                .o_data  (out_data)
            );

            pipe_skid_entry #(
                .WIDTH   (WIDTH),
                .RST_VAL (BUBBLE)
            ) u_skid (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_data  (in_data),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_dout)
            );
        end else begin : g_noskid
            logic w_main_load;
            logic w_main_clear;

            assign in_ready     = ~out_valid | out_ready;
            assign w_main_load  = w_accept;
            assign w_main_clear = flush | (w_consume & ~w_accept);

            pipe_skid_entry #(
                .WIDTH   (WIDTH),
                .RST_VAL (BUBBLE)
            ) u_main (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_main_load),
                .i_clear (w_main_clear),
                .i_data  (in_data),
                .o_valid (out_valid),
                .o_data  (out_data)
            );
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance on a shared clock.
// Counter checks compile in only with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned W = IFID_W;
    localparam logic [W-1:0] BUB = IFID_BUBBLE;

    logic         clk;
    logic         reset;

    logic         in_valid, in_ready, out_valid, out_ready, flush;
    logic [W-1:0] in_data, out_data;

    logic         in_valid0, in_ready0, out_valid0, out_ready0, flush0;
    logic [W-1:0] in_data0, out_data0;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cnt, bubble_cnt, stall_cnt0, bubble_cnt0;
`endif

    int unsigned  checks;
    int unsigned  failures;

    pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .BUBBLE(BUB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
`endif
        .flush      (flush)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(1'b0), .BUBBLE(BUB)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .in_data    (in_data0),
        .out_valid  (out_valid0),
        .out_ready  (out_ready0),
        .out_data   (out_data0),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt  (stall_cnt0),
        .bubble_cnt (bubble_cnt0),
`endif
        .flush      (flush0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] PA = 96'hAAAA_0001_0000_0000_0000_00A0;
    localparam logic [W-1:0] PB = 96'hBBBB_0002_0000_0000_0000_00B0;
    localparam logic [W-1:0] PC = 96'hCCCC_0003_0000_0000_0000_00C0;
    localparam logic [W-1:0] PD = 96'hDDDD_0004_0000_0000_0000_00D0;
    localparam logic [W-1:0] PE = 96'hEEEE_0005_0000_0000_0000_00E0;
    localparam logic [W-1:0] PF = 96'hFFFF_0006_0000_0000_0000_00F0;

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        in_valid = 1'b1; in_data = PA; out_ready = 1'b1; flush = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0; flush0 = 1'b0;

        // Reset with a valid payload offered.
        step(); step();
        chk("rst_out_valid", W'(out_valid), W'(1'b0));
        chk("rst_out_data", out_data, BUB);
        chk("rst_bubble_top", W'(out_data[W-1 -: 32]), W'(32'h00000013));
        chk("rst_in_ready", W'(in_ready), W'(1'b1));
        chk("rst_out_data0", out_data0, BUB);
        reset = 1'b1;
        step();
        chk("first_accept_valid", W'(out_valid), W'(1'b1));
        chk("first_accept_data", out_data, PA);
        in_valid = 1'b0;
        step();
        chk("drain_valid", W'(out_valid), W'(1'b0));
        chk("drain_bubble", out_data, BUB);

        // Streaming 1..8 with full throughput.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = W'(i);
            step();
            chk("stream_valid", W'(out_valid), W'(1'b1));
            chk("stream_data", out_data, W'(i));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", W'(out_valid), W'(1'b0));

        // Skid: A held, B into skid, C stalled.
        out_ready = 1'b0; in_valid = 1'b1; in_data = PA;
        step();
        chk("skid_a_data", out_data, PA);
        chk("skid_a_ready", W'(in_ready), W'(1'b1));
        in_data = PB;
        step();
        chk("skid_hold_a", out_data, PA);
        chk("skid_ready_low", W'(in_ready), W'(1'b0));
        in_data = PC;
        step();
        chk("skid_hold_a2", out_data, PA);
        chk("skid_ready_low2", W'(in_ready), W'(1'b0));
        out_ready = 1'b1;
        step();
        chk("skid_out_b", out_data, PB);
        chk("skid_ready_back", W'(in_ready), W'(1'b1));
        step();
        chk("skid_out_c", out_data, PC);
        chk("skid_out_c_valid", W'(out_valid), W'(1'b1));
        in_valid = 1'b0;
        step();
        chk("skid_drained", W'(out_valid), W'(1'b0));

        // Flush in SKID state while D is offered.
        out_ready = 1'b0; in_valid = 1'b1; in_data = PE;
        step();
        in_data = PF;
        step();
        chk("pre_flush_ready", W'(in_ready), W'(1'b0));
        flush = 1'b1; in_data = PD;
        step();
        chk("flush_valid", W'(out_valid), W'(1'b0));
        chk("flush_bubble", out_data, BUB);
        chk("flush_ready", W'(in_ready), W'(1'b1));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("flush_no_d_valid", W'(out_valid), W'(1'b0));
        chk("flush_no_d_data", out_data, BUB);

        // Flush overrides a same-cycle accept in FULL.
        out_ready = 1'b0; in_valid = 1'b1; in_data = PE;
        step();
        flush = 1'b1; in_data = PD;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_valid", W'(out_valid), W'(1'b0));
        chk("flush_full_data", out_data, BUB);
        out_ready = 1'b1;
        step();
        chk("flush_full_no_d", W'(out_valid), W'(1'b0));

        // SKID=0: combinational in_ready.
        in_valid0 = 1'b1; in_data0 = PA; out_ready0 = 1'b0;
        #1;
        chk("ns_ready_empty", W'(in_ready0), W'(1'b1));
        step();
        chk("ns_out_a", out_data0, PA);
        chk("ns_ready_bp", W'(in_ready0), W'(1'b0));
        in_data0 = PB;
        step();
        chk("ns_hold_a", out_data0, PA);
        out_ready0 = 1'b1;
        #1;
        chk("ns_ready_same_cycle", W'(in_ready0), W'(1'b1));
        step();
        chk("ns_out_b", out_data0, PB);
        in_valid0 = 1'b0;
        step();
        chk("ns_empty_valid", W'(out_valid0), W'(1'b0));
        chk("ns_empty_bubble", out_data0, BUB);

`ifdef PIPE_STAGE_PERF_EN
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        step();
        chk("perf_rst_stall", W'(stall_cnt), W'(32'd0));
        chk("perf_rst_bubble", W'(bubble_cnt), W'(32'd0));
        reset = 1'b1; in_valid = 1'b1; in_data = PA;
        step();
        in_valid = 1'b0;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step(); step();
        chk("perf_stall", W'(stall_cnt), W'(32'd3));
        chk("perf_bubble", W'(bubble_cnt), W'(32'd3));
`else
        step();
        chk("idle_valid", W'(out_valid), W'(1'b0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
